// File: rtl/sram_pkg.sv
// Shared definitions for the byte-enabled dual-port SRAM: read-during-write modes,
// clear-engine states and the byte-merge helper.
package sram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } clr_state_e;

  // One byte lane of the merge: the top applies this across every lane of the word.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output stage for one port: captures accepted read data, optional second
// register, val pulses once per accepted read and dout holds otherwise.
module sram_rd_pipe #(
  parameter int W       = 16,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_acc,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_dout,
  output logic         o_val
);

  logic [W-1:0] r_d1;
  logic         r_v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= i_acc;
      if (i_acc) r_d1 <= i_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] r_d2;
      logic         r_v2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign o_dout = r_d2;
      assign o_val  = r_v2;
    end else begin : g_noreg
      assign o_dout = r_d1;
      assign o_val  = r_v1;
    end
  endgenerate

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte enables (A: read/write, B: read-only) and a
// clear engine that fills every word with INIT_VALUE after each reset.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   BIT_WIDTH  = 16,
  parameter int                   RDW_MODE   = 0,
  parameter int                   OUT_REG    = 0,
  parameter logic [BIT_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                   clka,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [BIT_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]  addra,
  input  logic [BIT_WIDTH-1:0]   dina,
  output logic [BIT_WIDTH-1:0]   douta,
  output logic                   vala,
  input  logic                   enb,
  input  logic [ADDR_WIDTH-1:0]  addrb,
  output logic [BIT_WIDTH-1:0]   doutb,
  output logic                   valb,
  output logic                   init_busy
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = BIT_WIDTH / 8;

  generate
    if ((BIT_WIDTH % 8) != 0 || (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) ||
        OUT_REG > 1 || OUT_REG < 0) begin : g_bad_param
      $fatal(1, "sram_dp_be: illegal parameter combination");
    end
  endgenerate

  clr_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [BIT_WIDTH-1:0]  r_mem [DEPTH];

  logic                  w_run, w_acc_a, w_acc_b, w_wr;
  logic [BIT_WIDTH-1:0]  w_olda, w_oldb, w_merged, w_rda, w_rdb;

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  assign init_busy = !w_run;
  assign w_acc_a   = w_run & ena;
  assign w_acc_b   = w_run & enb;
  assign w_wr      = w_acc_a & (|wea);

  // The array itself is never reset; the clear engine owns it until RUN.
  always_ff @(posedge clka) begin
    if (!w_run) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else if (ena) begin
      for (int k = 0; k < NBYTES; k++)
        if (wea[k]) r_mem[addra][8*k +: 8] <= dina[8*k +: 8];
    end
  end

  assign w_olda = r_mem[addra];
  assign w_oldb = r_mem[addrb];

  generate
    for (genvar k = 0; k < NBYTES; k++) begin : g_merge
      assign w_merged[8*k +: 8] = byte_merge(w_olda[8*k +: 8], dina[8*k +: 8], wea[k]);
    end
  endgenerate

  // With wea=0 the merged word equals the old one, so port A needs no address compare.
  assign w_rda = (RDW_MODE == RDW_WRITE_FIRST) ? w_merged : w_olda;
  assign w_rdb = (RDW_MODE == RDW_WRITE_FIRST && w_wr && addrb == addra) ? w_merged : w_oldb;

  sram_rd_pipe #(.W(BIT_WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk   (clka),
    .rst_n (rst),
    .i_acc (w_acc_a),
    .i_data(w_rda),
    .o_dout(douta),
    .o_val (vala)
  );

  sram_rd_pipe #(.W(BIT_WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk   (clka),
    .rst_n (rst),
    .i_acc (w_acc_b),
    .i_data(w_rdb),
    .o_dout(doutb),
    .o_val (valb)
  );

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench: two configurations (read-first/1-cycle and write-first/2-cycle)
// driven with identical stimulus and checked against a word-array reference model.
module tb_sram_dp_be;

  localparam logic [15:0] INITV = 16'hA5A5;

  logic        clka = 1'b0;
  logic        rst;
  logic        ena, enb;
  logic [1:0]  wea;
  logic [3:0]  addra, addrb;
  logic [15:0] dina;
  logic [15:0] douta0, doutb0, douta1, doutb1;
  logic        vala0, valb0, vala1, valb1, busy0, busy1;

  always #5 clka = ~clka;

  sram_dp_be #(.ADDR_WIDTH(4), .BIT_WIDTH(16), .RDW_MODE(0), .OUT_REG(0), .INIT_VALUE(INITV)) dut0 (
    .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta0), .vala(vala0), .enb(enb), .addrb(addrb), .doutb(doutb0), .valb(valb0),
    .init_busy(busy0));

  sram_dp_be #(.ADDR_WIDTH(4), .BIT_WIDTH(16), .RDW_MODE(1), .OUT_REG(1), .INIT_VALUE(INITV)) dut1 (
    .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .vala(vala1), .enb(enb), .addrb(addrb), .doutb(doutb1), .valb(valb1),
    .init_busy(busy1));

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  // stream 0: dut0 A, 1: dut0 B, 2: dut1 A, 3: dut1 B
  exp_t        sq [4][$];
  logic [15:0] last [4];
  logic [15:0] mdl [16];
  int          cyc = 0;
  int          init_left = 16;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clka) begin
    cyc++;
    if (rst && init_left > 0) init_left--;
  end

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[0]) r[7:0]  = n[7:0];
    if (be[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  function automatic void push(input int s, input logic [15:0] d, input int due);
    exp_t e;
    e.d   = d;
    e.due = due;
    sq[s].push_back(e);
  endfunction

  always @(negedge clka) begin
    logic [15:0] d;
    logic        v;
    exp_t        e;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       begin d = douta0; v = vala0; end
        1:       begin d = doutb0; v = valb0; end
        2:       begin d = douta1; v = vala1; end
        default: begin d = doutb1; v = valb1; end
      endcase
      checks++;
      if (v) begin
        if (sq[s].size() == 0) begin
          errors++;
          $display("FAIL unexpected_val s%0d cyc %0d dout %h, no read outstanding", s, cyc, d);
        end else begin
          e = sq[s].pop_front();
          if (d !== e.d || e.due != cyc) begin
            errors++;
            $display("FAIL read_data s%0d cyc %0d got %h expected %h (due cyc %0d)",
                     s, cyc, d, e.d, e.due);
          end
          last[s] = e.d;
        end
      end else begin
        if (d !== last[s]) begin
          errors++;
          $display("FAIL hold s%0d cyc %0d got %h expected %h", s, cyc, d, last[s]);
        end
        if (sq[s].size() != 0 && sq[s][0].due <= cyc) begin
          errors++;
          $display("FAIL missing_val s%0d cyc %0d expected %h due cyc %0d", s, cyc,
                   sq[s][0].d, sq[s][0].due);
          e = sq[s].pop_front();
        end
      end
    end
    checks++;
    if (busy0 !== (init_left > 0) || busy1 !== (init_left > 0)) begin
      errors++;
      $display("FAIL init_busy cyc %0d got %b/%b expected %b", cyc, busy0, busy1, init_left > 0);
    end
  end

  task automatic drive(input logic ea, input logic [1:0] wa, input logic [3:0] aa,
                       input logic [15:0] da, input logic eb, input logic [3:0] ab);
    logic [15:0] o, m, ob;
    ena = ea; wea = wa; addra = aa; dina = da; enb = eb; addrb = ab;
    if (rst && init_left == 0) begin
      o = mdl[aa];
      m = merge(o, da, wa);
      if (ea) begin
        push(0, o, cyc + 1);
        push(2, m, cyc + 2);
      end
      if (eb) begin
        ob = mdl[ab];
        push(1, ob, cyc + 1);
        push(3, (ea && wa != 2'b00 && ab == aa) ? m : ob, cyc + 2);
      end
      if (ea) mdl[aa] = m;
    end
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    init_left = 16;
    for (int s = 0; s < 4; s++) begin
      sq[s].delete();
      last[s] = '0;
    end
    idle(hold);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = INITV;
  endtask

  task automatic stream_b();
    for (int i = 0; i < 16; i++) drive(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, 4'(i));
  endtask

  initial begin
    rst = 1'b0; ena = 0; enb = 0; wea = 0; addra = 0; addrb = 0; dina = 0;
    for (int s = 0; s < 4; s++) last[s] = '0;
    @(posedge clka);
    #1;
    do_reset(3);

    // Port activity during clearing must be ignored.
    repeat (16) drive(1'b1, 2'b11, 4'd0, 16'h7777, 1'b1, 4'd0);
    idle(2);
    stream_b();
    drive(1'b1, 2'b00, 4'd0, 16'd0, 1'b0, 4'd0);
    idle(4);

    drive(1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 4'd0);
    drive(1'b1, 2'b10, 4'd3, 16'hFF00, 1'b0, 4'd0);
    drive(1'b1, 2'b00, 4'd3, 16'd0, 1'b1, 4'd3);
    idle(3);

    drive(1'b1, 2'b11, 4'd5, 16'h0000, 1'b0, 4'd0);
    drive(1'b1, 2'b01, 4'd5, 16'hBEEF, 1'b1, 4'd5);
    drive(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, 4'd5);
    idle(3);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
            $urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)));
    idle(3);

    // Reset again, then once more seven cycles into the clear.
    do_reset(2);
    idle(7);
    do_reset(2);
    idle(16);
    stream_b();
    idle(4);

    for (int s = 0; s < 4; s++) begin
      checks++;
      if (sq[s].size() != 0) begin
        errors++;
        $display("FAIL drain s%0d got %0d outstanding expected 0", s, sq[s].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Parametrised simple-dual-port synchronous SRAM with byte write enables and a built-in clear engine. Port A reads and writes; port B is read-only. Both ports share one clock. Read-during-write behaviour and the output register stage are selectable by parameter. Used as the general scratch/buffer memory for datapath blocks that need concurrent write and read access.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 1<<ADDR_WIDTH words
BIT_WIDTH, 16, word width; must be a multiple of 8; NBYTES = BIT_WIDTH/8
RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
INIT_VALUE, 0, BIT_WIDTH-wide value written to every word by the clear engine

Ports:
clka  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
ena  in  1  port A enable (read and/or write)
wea  in  NBYTES  port A byte write enables; bit k covers dina[8k+7:8k]
addra  in  ADDR_WIDTH  port A address
dina  in  BIT_WIDTH  port A write data
douta  out  BIT_WIDTH  port A read data
vala  out  1  douta holds data for an accepted read
enb  in  1  port B read enable
addrb  in  ADDR_WIDTH  port B address
doutb  out  BIT_WIDTH  port B read data
valb  out  1  doutb holds data for an accepted read
init_busy  out  1  clear engine active; ports ignored

Behaviour:
- Reset (rst=0, asynchronous): douta=0, doutb=0, vala=0, valb=0, init_busy=1, clear counter=0, pipeline stages cleared. Memory array has no reset.
- Clear FSM, states INIT and RUN. Reset forces INIT.
- INIT: one word per clock, SRAM[cnt] <= INIT_VALUE, cnt increments 0..DEPTH-1. After the write to DEPTH-1, go to RUN and drop init_busy on the same edge. INIT lasts exactly DEPTH cycles after rst rises.
- INIT: ena, enb, wea ignored. No writes or reads accepted; vala and valb stay 0.
- Reset asserted mid-INIT or in RUN: immediate return to INIT, cnt=0, full clear restarts.
- RUN, port A: when ena=1, byte k of SRAM[addra] <= dina byte k for each wea[k]=1. Unselected bytes are unchanged. A read of addra is accepted whenever ena=1, including wea=0.
- RUN, port B: when enb=1, a read of addrb is accepted.
- Latency, OUT_REG=0: data and val appear on the edge after acceptance. OUT_REG=1: one edge later. val is asserted for exactly one cycle per accepted read; back-to-back reads are allowed every cycle.
- When no read is accepted, dout holds its last value and val=0.
- Read-during-write, same address (port A's own read, or port B reading the address port A writes):
  - RDW_MODE=0: return the full old word.
  - RDW_MODE=1: return the merged word (written bytes new, others old).
- Different addresses: no interaction.
- Address width is exact; no out-of-range case exists.
- Elaboration check: BIT_WIDTH%8 != 0 or RDW_MODE>1 or OUT_REG>1 is a fatal error.

Decomposition:
- Shared package sram_pkg: RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants, clear-FSM state encoding (ST_INIT, ST_RUN), and the byte-merge function (old word, new word, byte enables -> merged word).
- One sub-module is natural: sram_rd_pipe, per port. It takes raw read data plus the accept flag and produces dout and val with the OUT_REG stage; it is instantiated twice.
- The clear FSM and the array stay in the top level.

Test Plan:
- Reset release, DEPTH=16, INIT_VALUE=16'hA5A5 -> init_busy high for exactly 16 cycles. A port B read of every address then returns 16'hA5A5 with valb pulsing one cycle each.
- Byte write: addra=3, dina=16'h1234, wea=2'b11; then dina=16'hFF00, wea=2'b10 -> read of addr 3 returns 16'hFF34 one cycle after the enable (OUT_REG=0) and two cycles after it (OUT_REG=1).
- Collision: SRAM[5]=16'h0000. Port A writes 16'hBEEF, wea=2'b01, while port B reads addr 5 in the same cycle -> doutb=16'h0000 for RDW_MODE=0, 16'h00EF for RDW_MODE=1. Next read of addr 5 returns 16'h00EF.
- Ignore during INIT: ena=1, wea=2'b11, addra=0, dina=16'h7777 applied during INIT -> vala stays 0. Addr 0 reads INIT_VALUE after init completes.
- Reset mid-operation: assert rst at init cycle 7, then release -> init_busy high for a full 16 cycles again. douta, doutb, vala, valb are 0 while in reset. Previously written data is overwritten with INIT_VALUE.
- Streaming: enb=1 with addrb=0..15 on consecutive cycles -> valb high 16 consecutive cycles with data in address order. With enb=0, doutb holds the last word and valb=0.
